calc_engine_seq: RTL and testbench

- Parametrised, multi-cycle signed fixed-point decimal arithmetic core; successor to the single-cycle calculator compute path.
- Takes two BCD operands with sign and decimal-point position and returns a BCD result with fixed FRAC fractional digits.
- Supports add, sub, mul and div, with start/busy/done handshake plus overflow and divide-by-zero flags.
- Sits between the input state machine and the display driver.

---
 rtl/calc_pkg.sv | 22 ++
 rtl/const_div10.sv | 16 +
 rtl/calc_engine_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_calc_engine_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the sequential fixed-point decimal calculator:
// default sizing, operation encoding and controller states.
package calc_pkg;

  localparam int DEF_NDIG  = 8;
  localparam int DEF_FRAC  = 2;
  localparam int DEF_ACC_W = 64;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    ALIGN,
    CALC,
    TOBCD
  } state_t;

endpackage

// File: rtl/const_div10.sv
// Combinational divide-by-ten returning the quotient and the single decimal
// digit left over; shared by scaling and binary-to-BCD conversion.
module const_div10
  import calc_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] i_x,
  output logic [ACC_W-1:0] o_q,
  output logic [3:0]       o_r
);

  assign o_q = i_x / ACC_W'(10);
  assign o_r = 4'(i_x % ACC_W'(10));

endmodule

// File: rtl/calc_engine_seq.sv
// Multi-cycle signed fixed-point BCD calculator: converts both operands to
// binary, aligns them to FRAC fractional digits, computes, and converts back.
module calc_engine_seq
  import calc_pkg::*;
#(
  parameter int NDIG  = DEF_NDIG,
  parameter int FRAC  = DEF_FRAC,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk_db,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              op,
  input  logic [NDIG*4-1:0]       a_digits,
  input  logic [$clog2(NDIG)-1:0] a_dp,
  input  logic                    a_neg,
  input  logic [NDIG*4-1:0]       b_digits,
  input  logic [$clog2(NDIG)-1:0] b_dp,
  input  logic                    b_neg,
  output logic                    busy,
  output logic                    done,
  output logic [NDIG*4-1:0]       res_digits,
  output logic [$clog2(NDIG)-1:0] res_dp,
  output logic                    res_neg,
  output logic                    overflow,
  output logic                    div_zero
);

  localparam int DPW   = $clog2(NDIG);
  localparam int CNT_W = $clog2(ACC_W + FRAC + NDIG + 1);
  localparam logic [DPW-1:0]    FRAC_DP      = DPW'(FRAC);
  localparam logic [CNT_W-1:0]  CNT_DIG_END  = CNT_W'(NDIG - 1);
  localparam logic [CNT_W-1:0]  CNT_CALC_END = CNT_W'(ACC_W + FRAC - 1);
  localparam logic [CNT_W-1:0]  CNT_MUL_END  = CNT_W'(ACC_W);
  localparam logic [CNT_W-1:0]  CNT_PRESCALE = CNT_W'(FRAC);
  localparam logic [NDIG*4-1:0] ALL_NINES    = {NDIG{4'h9}};

  state_t r_state, w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_op;
  logic                  r_aNeg, r_bNeg, r_resNeg;
  logic                  r_aUp, r_bUp;
  logic [DPW-1:0]        r_aSteps, r_bSteps;
  logic [NDIG*4-1:0]     r_aDig, r_bDig;
  logic [(NDIG-1)*4-1:0] r_bcd;
  logic [ACC_W-1:0]      r_accA, r_accB, r_res, r_rem;

  function automatic logic [ACC_W-1:0] times10(input logic [ACC_W-1:0] x);
    return (x << 3) + (x << 1);
  endfunction

  // Digits are consumed most significant first; non-decimal codes saturate to 9.
  logic [3:0] w_nibA, w_nibB, w_digA, w_digB;
  assign w_nibA = r_aDig[NDIG*4-1 -: 4];
  assign w_nibB = r_bDig[NDIG*4-1 -: 4];
  assign w_digA = (w_nibA > 4'd9) ? 4'd9 : w_nibA;
  assign w_digB = (w_nibB > 4'd9) ? 4'd9 : w_nibB;

  logic [ACC_W-1:0] w_div10In, w_q, w_qB;
  logic [3:0]       w_r, w_unusedRB;
  assign w_div10In = (r_state == ALIGN) ? r_accA : r_res;

  const_div10 #(.ACC_W(ACC_W)) u_div10 (
    .i_x(w_div10In),
    .o_q(w_q),
    .o_r(w_r)
  );

  const_div10 #(.ACC_W(ACC_W)) u_div10B (
    .i_x(r_accB),
    .o_q(w_qB),
    .o_r(w_unusedRB)
  );

  logic w_bNegEff, w_aGeB, w_divZero, w_fits, w_ovf;
  logic [ACC_W-1:0]  w_remShift, w_remNext, w_quoNext;
  logic [NDIG*4-1:0] w_bcdFinal;

  assign w_bNegEff = r_bNeg ^ (r_op == OP_SUB);
  assign w_aGeB    = (r_accA >= r_accB);
  assign w_divZero = (r_op == OP_DIV) && (r_cnt == '0) && (r_accB == '0);

  // Restoring division: a set top remainder bit means the shifted value already exceeds any divisor.
  assign w_remShift = {r_rem[ACC_W-2:0], r_accA[ACC_W-1]};
  assign w_fits     = r_rem[ACC_W-1] | (w_remShift >= r_accB);
  assign w_remNext  = w_fits ? (w_remShift - r_accB) : w_remShift;
  assign w_quoNext  = {r_accA[ACC_W-2:0], w_fits};

  assign w_bcdFinal = {w_r, r_bcd};
  assign w_ovf      = (w_q != '0);

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk_db or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = CONV;
      CONV:  if (r_cnt == CNT_DIG_END)
               w_next = (r_aSteps != '0 || r_bSteps != '0) ? ALIGN : CALC;
      ALIGN: if (r_aSteps <= DPW'(1) && r_bSteps <= DPW'(1)) w_next = CALC;
      CALC: begin
        if (r_op == OP_ADD || r_op == OP_SUB) w_next = TOBCD;
        else if (w_divZero)                   w_next = IDLE;
        else if (r_cnt == CNT_CALC_END)       w_next = TOBCD;
      end
      TOBCD: if (r_cnt == CNT_DIG_END) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_db or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_op       <= OP_ADD;
      r_aNeg     <= 1'b0;
      r_bNeg     <= 1'b0;
      r_resNeg   <= 1'b0;
      r_aUp      <= 1'b0;
      r_bUp      <= 1'b0;
      r_aSteps   <= '0;
      r_bSteps   <= '0;
      r_aDig     <= '0;
      r_bDig     <= '0;
      r_bcd      <= '0;
      r_accA     <= '0;
      r_accB     <= '0;
      r_res      <= '0;
      r_rem      <= '0;
      done       <= 1'b0;
      res_digits <= '0;
      res_dp     <= '0;
      res_neg    <= 1'b0;
      overflow   <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      done  <= 1'b0;
      r_cnt <= (r_state == IDLE || w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
      case (r_state)
        IDLE: if (start) begin
          r_op     <= op;
          r_aDig   <= a_digits;
          r_bDig   <= b_digits;
          r_aNeg   <= a_neg;
          r_bNeg   <= b_neg;
          r_aUp    <= (a_dp < FRAC_DP);
          r_bUp    <= (b_dp < FRAC_DP);
          r_aSteps <= (a_dp < FRAC_DP) ? FRAC_DP - a_dp : a_dp - FRAC_DP;
          r_bSteps <= (b_dp < FRAC_DP) ? FRAC_DP - b_dp : b_dp - FRAC_DP;
          r_accA   <= '0;
          r_accB   <= '0;
          r_res    <= '0;
          r_rem    <= '0;
        end
        CONV: begin
          r_accA <= times10(r_accA) + ACC_W'(w_digA);
          r_accB <= times10(r_accB) + ACC_W'(w_digB);
          r_aDig <= r_aDig << 4;
          r_bDig <= r_bDig << 4;
        end
        ALIGN: begin
          if (r_aSteps != '0) begin
            r_accA   <= r_aUp ? times10(r_accA) : w_q;
            r_aSteps <= r_aSteps - DPW'(1);
          end
          if (r_bSteps != '0) begin
            r_accB   <= r_bUp ? times10(r_accB) : w_qB;
            r_bSteps <= r_bSteps - DPW'(1);
          end
        end
        CALC: case (r_op)
          OP_ADD, OP_SUB: begin
            if (r_aNeg == w_bNegEff) begin
              r_res    <= r_accA + r_accB;
              r_resNeg <= r_aNeg;
            end else if (w_aGeB) begin
              r_res    <= r_accA - r_accB;
              r_resNeg <= r_aNeg;
            end else begin
              r_res    <= r_accB - r_accA;
              r_resNeg <= w_bNegEff;
            end
          end
          OP_MUL: begin
            r_resNeg <= r_aNeg ^ r_bNeg;
            if (r_cnt < CNT_MUL_END) begin
              if (r_accB[0]) r_res <= r_res + r_accA;
              r_accA <= r_accA << 1;
              r_accB <= r_accB >> 1;
            end else begin
              r_res <= w_q;
            end
          end
          default: begin
            r_resNeg <= r_aNeg ^ r_bNeg;
            if (w_divZero) begin
              done       <= 1'b1;
              div_zero   <= 1'b1;
              overflow   <= 1'b0;
              res_digits <= '0;
              res_neg    <= 1'b0;
              res_dp     <= FRAC_DP;
            end else if (r_cnt < CNT_PRESCALE) begin
              r_accA <= times10(r_accA);
            end else begin
              r_accA <= w_quoNext;
              r_rem  <= w_remNext;
              if (r_cnt == CNT_CALC_END) r_res <= w_quoNext;
            end
          end
        endcase
        // Digits leave least significant first; the last one is merged straight into the result.
        TOBCD: begin
          r_res <= w_q;
          r_bcd <= {w_r, r_bcd[(NDIG-1)*4-1:4]};
          if (r_cnt == CNT_DIG_END) begin
            done       <= 1'b1;
            overflow   <= w_ovf;
            div_zero   <= 1'b0;
            res_dp     <= FRAC_DP;
            res_digits <= w_ovf ? ALL_NINES : w_bcdFinal;
            res_neg    <= r_resNeg && (w_ovf || w_bcdFinal != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_engine_seq.sv
// Directed self-checking bench for calc_engine_seq at NDIG=8, FRAC=2, ACC_W=64.
module tb_calc_engine_seq;

  logic        clk_db = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a_digits, b_digits;
  logic [2:0]  a_dp, b_dp;
  logic        a_neg, b_neg;
  logic        busy, done, res_neg, overflow, div_zero;
  logic [31:0] res_digits;
  logic [2:0]  res_dp;

  int nChecks = 0;
  int nFails  = 0;

  calc_engine_seq #(.NDIG(8), .FRAC(2), .ACC_W(64)) dut (
    .clk_db    (clk_db),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a_digits  (a_digits),
    .a_dp      (a_dp),
    .a_neg     (a_neg),
    .b_digits  (b_digits),
    .b_dp      (b_dp),
    .b_neg     (b_neg),
    .busy      (busy),
    .done      (done),
    .res_digits(res_digits),
    .res_dp    (res_dp),
    .res_neg   (res_neg),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  always #5 clk_db = ~clk_db;

  // Latency counts the start-sampling edge as 1; inputs are scrambled right after it.
  task automatic run_op(input logic [1:0] iOp, input logic [31:0] iA, input logic [2:0] iADp,
                        input logic iANeg, input logic [31:0] iB, input logic [2:0] iBDp,
                        input logic iBNeg, output int lat);
    @(negedge clk_db);
    op = iOp; a_digits = iA; a_dp = iADp; a_neg = iANeg;
    b_digits = iB; b_dp = iBDp; b_neg = iBNeg; start = 1'b1;
    @(posedge clk_db);
    #1;
    start = 1'b0; op = ~iOp; a_digits = 32'h87654321; a_dp = 3'd7; a_neg = ~iANeg;
    b_digits = 32'h0; b_dp = 3'd5; b_neg = ~iBNeg;
    lat = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_db);
      if (done) break;
      @(posedge clk_db);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'd0;
    a_digits = '0; a_dp = '0; a_neg = 1'b0; b_digits = '0; b_dp = '0; b_neg = 1'b0;
    repeat (2) @(posedge clk_db);
    @(negedge clk_db);
    nChecks++;
    if ({busy, done, res_neg, overflow, div_zero, res_dp, res_digits} !== 40'h0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs got %h want 0", {busy, done, res_neg, overflow, div_zero, res_dp, res_digits});
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    run_op(2'd0, 32'h00000125, 3'd1, 1'b0, 32'h00000375, 3'd2, 1'b0, lat);
    nChecks++;
    if (lat !== 19) begin nFails++; $display("[TB] FAIL add_latency got %0d want 19", lat); end
    nChecks++;
    if (res_digits !== 32'h00001625) begin nFails++; $display("[TB] FAIL add_digits got %h want 00001625", res_digits); end
    nChecks++;
    if ({res_dp, res_neg, overflow, div_zero} !== {3'd2, 3'b000}) begin
      nFails++; $display("[TB] FAIL add_flags got dp=%0d neg=%b ovf=%b dz=%b want dp=2 others 0", res_dp, res_neg, overflow, div_zero);
    end
  endtask

  task automatic test_sub();
    int lat;
    run_op(2'd1, 32'h00000003, 3'd0, 1'b0, 32'h00000075, 3'd1, 1'b0, lat);
    nChecks++;
    if (lat !== 20) begin nFails++; $display("[TB] FAIL sub_latency got %0d want 20", lat); end
    nChecks++;
    if (res_digits !== 32'h00000450) begin nFails++; $display("[TB] FAIL sub_digits got %h want 00000450", res_digits); end
    nChecks++;
    if (res_neg !== 1'b1) begin nFails++; $display("[TB] FAIL sub_sign got %b want 1", res_neg); end
  endtask

  task automatic test_mul();
    int lat;
    run_op(2'd2, 32'h00000015, 3'd1, 1'b0, 32'h00000225, 3'd2, 1'b1, lat);
    nChecks++;
    if (lat !== 84) begin nFails++; $display("[TB] FAIL mul_latency got %0d want 84", lat); end
    nChecks++;
    if (res_digits !== 32'h00000337) begin nFails++; $display("[TB] FAIL mul_digits got %h want 00000337", res_digits); end
    nChecks++;
    if (res_neg !== 1'b1) begin nFails++; $display("[TB] FAIL mul_sign got %b want 1", res_neg); end
  endtask

  task automatic test_div();
    int lat;
    run_op(2'd3, 32'h00000010, 3'd0, 1'b1, 32'h00000003, 3'd0, 1'b1, lat);
    nChecks++;
    if (lat !== 85) begin nFails++; $display("[TB] FAIL div_latency got %0d want 85", lat); end
    nChecks++;
    if ({res_digits, res_neg, div_zero} !== {32'h00000333, 2'b00}) begin
      nFails++; $display("[TB] FAIL div_result got %h neg=%b dz=%b want 00000333 neg=0 dz=0", res_digits, res_neg, div_zero);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(2'd3, 32'h00000005, 3'd0, 1'b0, 32'h00000000, 3'd0, 1'b0, lat);
    nChecks++;
    if (lat !== 12) begin nFails++; $display("[TB] FAIL divzero_latency got %0d want 12", lat); end
    nChecks++;
    if ({div_zero, overflow, res_neg, res_digits} !== {3'b100, 32'h0}) begin
      nFails++; $display("[TB] FAIL divzero_result got dz=%b ovf=%b neg=%b digits=%h want dz=1 digits=0", div_zero, overflow, res_neg, res_digits);
    end
  endtask

  task automatic test_overflow();
    int lat;
    run_op(2'd2, 32'h99999999, 3'd2, 1'b0, 32'h00000100, 3'd0, 1'b0, lat);
    nChecks++;
    if (lat !== 85) begin nFails++; $display("[TB] FAIL ovf_latency got %0d want 85", lat); end
    nChecks++;
    if ({overflow, div_zero, res_digits} !== {2'b10, 32'h99999999}) begin
      nFails++; $display("[TB] FAIL ovf_result got ovf=%b dz=%b digits=%h want ovf=1 dz=0 digits=99999999", overflow, div_zero, res_digits);
    end
  endtask

  task automatic test_neg_zero();
    int lat;
    run_op(2'd0, 32'h00000001, 3'd3, 1'b1, 32'h00000000, 3'd2, 1'b0, lat);
    nChecks++;
    if (lat !== 19) begin nFails++; $display("[TB] FAIL negzero_latency got %0d want 19", lat); end
    nChecks++;
    if ({res_neg, overflow, res_digits} !== {2'b00, 32'h0}) begin
      nFails++; $display("[TB] FAIL negzero_result got neg=%b ovf=%b digits=%h want all 0", res_neg, overflow, res_digits);
    end
  endtask

  task automatic test_digit_clamp();
    int lat;
    run_op(2'd0, 32'h000000F1, 3'd0, 1'b0, 32'h0000000A, 3'd2, 1'b0, lat);
    nChecks++;
    if (res_digits !== 32'h00009109) begin nFails++; $display("[TB] FAIL clamp_digits got %h want 00009109", res_digits); end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    @(negedge clk_db);
    op = 2'd0; a_digits = 32'h00000125; a_dp = 3'd1; a_neg = 1'b0;
    b_digits = 32'h00000375; b_dp = 3'd2; b_neg = 1'b0; start = 1'b1;
    @(negedge clk_db);
    start = 1'b0;
    repeat (3) @(negedge clk_db);
    op = 2'd2; a_digits = 32'h00000777; start = 1'b1;
    @(negedge clk_db);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_db);
      if (done) dones++;
    end
    nChecks++;
    if (dones !== 1) begin nFails++; $display("[TB] FAIL busy_start_dones got %0d want 1", dones); end
    nChecks++;
    if (res_digits !== 32'h00001625) begin nFails++; $display("[TB] FAIL busy_start_digits got %h want 00001625", res_digits); end
  endtask

  task automatic test_reset_mid_op();
    int seen = 0;
    @(negedge clk_db);
    op = 2'd2; a_digits = 32'h00000015; a_dp = 3'd1; a_neg = 1'b0;
    b_digits = 32'h00000225; b_dp = 3'd2; b_neg = 1'b1; start = 1'b1;
    @(posedge clk_db);
    #1 start = 1'b0;
    repeat (40) @(posedge clk_db);
    #2 rst = 1'b1;
    #1;
    nChecks++;
    if ({busy, done, res_neg, res_dp, res_digits} !== 37'h0) begin
      nFails++; $display("[TB] FAIL async_reset got busy=%b done=%b neg=%b dp=%0d digits=%h want all 0", busy, done, res_neg, res_dp, res_digits);
    end
    @(negedge clk_db);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_db);
      if (done || busy) seen++;
    end
    nChecks++;
    if (seen !== 0) begin nFails++; $display("[TB] FAIL reset_abort got %0d active cycles want 0", seen); end
  endtask

  task automatic test_after_reset();
    int lat;
    run_op(2'd1, 32'h00000003, 3'd0, 1'b0, 32'h00000075, 3'd1, 1'b0, lat);
    nChecks++;
    if ({res_digits, res_neg, res_dp} !== {32'h00000450, 1'b1, 3'd2}) begin
      nFails++; $display("[TB] FAIL after_reset got %h neg=%b dp=%0d want 00000450 neg=1 dp=2", res_digits, res_neg, res_dp);
    end
    nChecks++;
    if (lat !== 20) begin nFails++; $display("[TB] FAIL after_reset_latency got %0d want 20", lat); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_div_zero();
    test_overflow();
    test_neg_zero();
    test_digit_clamp();
    test_back_to_back();
    test_reset_mid_op();
    test_after_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
